// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the runtime-loadable LUT writer.
// Optional readback (LUT_READBACK_EN) is handled in the modules that import this package.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } lut_state_e;

    function automatic int depth(input int in_bits);
        return 1 << in_bits;
    endfunction

    function automatic int beats(input int in_bits, input int word_w, input int out_bits);
        return depth(in_bits) / (word_w / out_bits);
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// DEPTH x OUT_BITS table: beat-wide write port, synchronous lookup read port,
// plus a beat-wide synchronous readback port when LUT_READBACK_EN is defined.
module lut_table_ram import lut_cfg_pkg::*; #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 8,
    localparam int DEPTH   = depth(IN_BITS),
    localparam int EPB     = WORD_W / OUT_BITS,
    localparam int BEATS   = beats(IN_BITS, WORD_W, OUT_BITS),
    localparam int BW      = addr_w(BEATS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [BW-1:0]       wr_addr_i,
    input  logic [WORD_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic [IN_BITS-1:0]  rd_addr_i,
`ifdef LUT_READBACK_EN
    input  logic                rb_rd_en_i,
    input  logic [BW-1:0]       rb_rd_addr_i,
    output logic [WORD_W-1:0]   rb_rd_data_o,
`endif
    output logic [OUT_BITS-1:0] rd_data_o
);

    logic [OUT_BITS-1:0] mem [DEPTH];
    logic [OUT_BITS-1:0] rd_data_q;

    // Entry j of a beat lands at beat_addr*EPB + j, lowest entry at lowest address.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int j = 0; j < EPB; j++) begin
                mem[IN_BITS'(int'(wr_addr_i) * EPB + j)] <= wr_data_i[j*OUT_BITS +: OUT_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

`ifdef LUT_READBACK_EN
    logic [WORD_W-1:0] rb_rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_rd_data_q <= '0;
        end else if (rb_rd_en_i) begin
            for (int j = 0; j < EPB; j++) begin
                rb_rd_data_q[j*OUT_BITS +: OUT_BITS] <= mem[IN_BITS'(int'(rb_rd_addr_i) * EPB + j)];
            end
        end
    end

    assign rb_rd_data_o = rb_rd_data_q;
`endif

endmodule

// File: rtl/lut_table_writer.sv
// Loads a LUT truth table from a config beat stream, then serves registered lookups.
// LUT_READBACK_EN adds rb_req/rb_data/rb_valid to stream the table back out in load order.
//
//   state | meaning
//   IDLE  | no table loaded, beats rejected (flag cfg_err), lookups blocked
//   LOAD  | cfg_ready high, accepting beats 0..BEATS-1
//   READY | table complete, cfg_done high, lookups (and readback) served
module lut_table_writer import lut_cfg_pkg::*; #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 8,
    localparam int BEATS   = beats(IN_BITS, WORD_W, OUT_BITS),
    localparam int BW      = addr_w(BEATS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic [IN_BITS-1:0]  lut_in,
    input  logic                lut_in_valid,
    output logic [OUT_BITS-1:0] lut_out,
`ifdef LUT_READBACK_EN
    input  logic                rb_req,
    output logic [WORD_W-1:0]   rb_data,
    output logic                rb_valid,
`endif
    output logic                lut_out_valid
);

    lut_state_e    state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          out_valid_q;
    logic          accept;
    logic          rd_en;

    // A start pulse outranks a coincident beat: the beat is dropped, not counted.
    assign accept = (state_q == LOAD) && cfg_valid && !cfg_start;
    assign rd_en  = (state_q == READY) && lut_in_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (cfg_valid && (state_q != LOAD));
        if (cfg_start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else if (accept) begin
            if (cnt_q == BW'(BEATS - 1)) begin
                state_d = READY;
            end else begin
                cnt_d = cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= rd_en;
        end
    end

    assign cfg_ready     = (state_q == LOAD);
    assign cfg_done      = (state_q == READY);
    assign cfg_err       = err_q;
    assign lut_out_valid = out_valid_q;

`ifdef LUT_READBACK_EN
    logic          rb_busy_q, rb_busy_d;
    logic [BW-1:0] rb_cnt_q, rb_cnt_d;
    logic          rb_valid_q;
    logic          rb_rd_en;
    logic [BW-1:0] rb_rd_addr;

    // rb_cnt_q is the next beat address to fetch once streaming has begun.
    always_comb begin
        rb_busy_d  = rb_busy_q;
        rb_cnt_d   = rb_cnt_q;
        rb_rd_en   = 1'b0;
        rb_rd_addr = rb_cnt_q;
        if (cfg_start) begin
            rb_busy_d = 1'b0;
        end else if (rb_busy_q) begin
            rb_rd_en = 1'b1;
            rb_cnt_d = rb_cnt_q + BW'(1);
            if (rb_cnt_q == BW'(BEATS - 1)) begin
                rb_busy_d = 1'b0;
            end
        end else if (rb_req && (state_q == READY)) begin
            rb_rd_en   = 1'b1;
            rb_rd_addr = '0;
            rb_cnt_d   = BW'(1);
            rb_busy_d  = (BEATS > 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_busy_q  <= 1'b0;
            rb_cnt_q   <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_busy_q  <= rb_busy_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_valid_q <= rb_rd_en;
        end
    end

    assign rb_valid = rb_valid_q;
`endif

    lut_table_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .WORD_W   (WORD_W)
    ) u_ram (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (accept),
        .wr_addr_i    (cnt_q),
        .wr_data_i    (cfg_data),
        .rd_en_i      (rd_en),
        .rd_addr_i    (lut_in),
`ifdef LUT_READBACK_EN
        .rb_rd_en_i   (rb_rd_en),
        .rb_rd_addr_i (rb_rd_addr),
        .rb_rd_data_o (rb_data),
`endif
        .rd_data_o    (lut_out)
    );

endmodule

// File: tb/tb_lut_table_writer.sv
// Scoreboard bench for lut_table_writer: expected lookups/readback beats are queued at issue
// time and popped by monitors whenever the DUT presents a valid output.
module tb_lut_table_writer;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 1;
    localparam int WORD_W   = 8;
    localparam int DEPTH    = 256;
    localparam int EPB      = 8;
    localparam int BEATS    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_start = 1'b0;
    logic [WORD_W-1:0]   cfg_data = '0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic                cfg_done;
    logic                cfg_err;
    logic [IN_BITS-1:0]  lut_in = '0;
    logic                lut_in_valid = 1'b0;
    logic [OUT_BITS-1:0] lut_out;
    logic                lut_out_valid;
`ifdef LUT_READBACK_EN
    logic                rb_req = 1'b0;
    logic [WORD_W-1:0]   rb_data;
    logic                rb_valid;
    logic [WORD_W-1:0]   rb_exp_q[$];
`endif

    int checks = 0;
    int errors = 0;

    logic [OUT_BITS-1:0] exp_q[$];
    logic [OUT_BITS-1:0] exp_tbl[DEPTH];
    logic [WORD_W-1:0]   tb_beats[BEATS];

    lut_table_writer #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .WORD_W   (WORD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .lut_in        (lut_in),
        .lut_in_valid  (lut_in_valid),
        .lut_out       (lut_out),
`ifdef LUT_READBACK_EN
        .rb_req        (rb_req),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
`endif
        .lut_out_valid (lut_out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        logic [OUT_BITS-1:0] e;
        if (lut_out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lookup_unexpected: got lut_out_valid=1 lut_out=%0h, required no output", lut_out);
            end else begin
                e = exp_q.pop_front();
                if (lut_out !== e) begin
                    errors++;
                    $display("FAIL lookup_data: got %0h required %0h", lut_out, e);
                end
            end
        end
    end

`ifdef LUT_READBACK_EN
    always @(negedge clk) begin
        logic [WORD_W-1:0] e;
        if (rb_valid) begin
            checks++;
            if (rb_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rb_unexpected: got rb_valid=1 rb_data=%0h, required no beat", rb_data);
            end else begin
                e = rb_exp_q.pop_front();
                if (rb_data !== e) begin
                    errors++;
                    $display("FAIL rb_data: got %0h required %0h", rb_data, e);
                end
            end
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_beat(input logic [WORD_W-1:0] d, input int gap);
        repeat (gap) tick();
        cfg_valid = 1'b1;
        cfg_data  = d;
        @(negedge clk);
        check("cfg_ready_in_load", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Sends tb_beats[] in order; the final beat optionally carries a coincident lookup.
    task automatic load_table(input int gap_max, input bit probe_last);
        for (int k = 0; k < BEATS - 1; k++) begin
            send_beat(tb_beats[k], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        cfg_valid = 1'b1;
        cfg_data  = tb_beats[BEATS-1];
        if (probe_last) begin
            lut_in_valid = 1'b1;
            lut_in       = '0;
        end
        @(negedge clk);
        check("cfg_done_before_last_beat", cfg_done, 0);
        tick();
        cfg_valid    = 1'b0;
        lut_in_valid = 1'b0;
        @(negedge clk);
        check("cfg_done_after_last_beat", cfg_done, 1);
        check("cfg_ready_after_last_beat", cfg_ready, 0);
        if (probe_last) check("lookup_on_last_beat_dropped", lut_out_valid, 0);
        for (int a = 0; a < DEPTH; a++) exp_tbl[a] = tb_beats[a / EPB][a % EPB];
        tick();
    endtask

    task automatic lookup(input int a);
        lut_in       = IN_BITS'(a);
        lut_in_valid = 1'b1;
        exp_q.push_back(exp_tbl[a]);
        tick();
        lut_in_valid = 1'b0;
        tick();
    endtask

    task automatic blocked(input int a, input string name);
        lut_in       = IN_BITS'(a);
        lut_in_valid = 1'b1;
        tick();
        lut_in_valid = 1'b0;
        @(negedge clk);
        check(name, lut_out_valid, 0);
        tick();
    endtask

    task automatic sweep();
        for (int a = 0; a < DEPTH; a++) begin
            lut_in       = IN_BITS'(a);
            lut_in_valid = 1'b1;
            exp_q.push_back(exp_tbl[a]);
            tick();
        end
        lut_in_valid = 1'b0;
        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("reset_cfg_ready", cfg_ready, 0);
        check("reset_cfg_done", cfg_done, 0);
        check("reset_cfg_err", cfg_err, 0);
        check("reset_lut_out_valid", lut_out_valid, 0);
        check("reset_lut_out", lut_out, 0);
        tick();
        blocked(0, "lookup_blocked_after_reset");

        // 8'hA5 everywhere: address 0 -> 1, address 1 -> 0, address 8'hFF -> 1
        for (int k = 0; k < BEATS; k++) tb_beats[k] = 8'hA5;
        pulse_start();
        load_table(0, 1);
        check("model_a5_addr0", exp_tbl[0], 1);
        check("model_a5_addr1", exp_tbl[1], 0);
        check("model_a5_addrff", exp_tbl[255], 1);
        lookup(0);
        lookup(1);
        lookup(255);
        sweep();

        // Gapped load of a per-beat distinct pattern
        for (int k = 0; k < BEATS; k++) tb_beats[k] = WORD_W'(k * 37 + 11);
        pulse_start();
        load_table(3, 0);
        sweep();

        // Restart after beat 10, with a beat coincident with the start pulse
        pulse_start();
        for (int k = 0; k <= 10; k++) send_beat(8'hFF, 0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("start_with_beat_no_err", cfg_err, 0);
        check("restart_cfg_done", cfg_done, 0);
        check("restart_cfg_ready", cfg_ready, 1);
        tick();
        for (int k = 0; k < BEATS; k++) tb_beats[k] = 8'h00;
        load_table(0, 0);
        sweep();

        // Reset in the middle of a load
        pulse_start();
        for (int k = 0; k <= 10; k++) send_beat(8'h5A, 0);
        do_reset();
        @(negedge clk);
        check("midload_rst_cfg_done", cfg_done, 0);
        check("midload_rst_cfg_ready", cfg_ready, 0);
        tick();
        blocked(5, "lookup_blocked_after_midload_rst");

        // Reload, then offer a beat in READY
        for (int k = 0; k < BEATS; k++) tb_beats[k] = WORD_W'(k * 5 + 3) ^ 8'h3C;
        pulse_start();
        load_table(1, 0);
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        @(negedge clk);
        check("ready_beat_cfg_ready", cfg_ready, 0);
        check("ready_beat_err_not_yet", cfg_err, 0);
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("ready_beat_cfg_err", cfg_err, 1);
        tick();
        sweep();
        pulse_start();
        @(negedge clk);
        check("cfg_err_sticky_over_start", cfg_err, 1);
        check("start_clears_done", cfg_done, 0);
        tick();

        // Random table, used for readback when enabled
        for (int k = 0; k < BEATS; k++) tb_beats[k] = WORD_W'($urandom);
        load_table(2, 0);
        sweep();
        check("cfg_err_still_set", cfg_err, 1);

`ifdef LUT_READBACK_EN
        for (int k = 0; k < BEATS; k++) rb_exp_q.push_back(tb_beats[k]);
        rb_req = 1'b1;
        tick();
        rb_req = 1'b0;
        @(negedge clk);
        check("rb_first_beat_latency", rb_valid, 1);
        tick();
        lookup(77);
        for (int i = 0; i < 40 && rb_exp_q.size() > 0; i++) tick();
        check("rb_all_beats_seen", rb_exp_q.size(), 0);
        tick();
        check("rb_valid_after_stream", rb_valid, 0);
`endif

        do_reset();
        @(negedge clk);
        check("final_rst_clears_err", cfg_err, 0);
        check("final_rst_clears_done", cfg_done, 0);
        check("final_rst_lut_out", lut_out, 0);
        check("scoreboard_empty_at_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
